// File: rtl/lcd1602_seq.sv
// lcd1602_seq: write-only bus sequencer for an HD44780-compatible LCD1602.
//
// The CPU pushes {RS, byte} pairs into a small FIFO. After reset the block waits
// a power-up delay and then plays a fixed init sequence. After that it drains the
// FIFO. Each byte goes through the same bus cycle: setup, E pulse, hold, and
// execution delay. Firmware polls busy/full/ovf and needs no software delays.
//
// Ports:
//   in_clock   system clock, rising edge
//   rst        synchronous reset, active-high
//   wr_stb     one-cycle write strobe (synchronous to in_clock)
//   wr_rs      RS for the pushed byte (0 = command, 1 = data)
//   wr_data    byte to send
//   busy       init pending, FIFO non-empty, or a transfer/delay in progress
//   full       FIFO holds FIFO_DEPTH entries
//   ovf        sticky dropped-write flag, cleared only by rst
//   init_done  init sequence complete
//   lcd_e      LCD enable
//   lcd_rs     LCD register select
//   lcd_rw     LCD read/write, tied low
//   lcd_db     LCD data bus
module lcd1602_seq #(
  parameter int unsigned T_POWERUP  = 750000,
  parameter int unsigned T_SETUP    = 2,
  parameter int unsigned T_PULSE    = 12,
  parameter int unsigned T_HOLD     = 2,
  parameter int unsigned T_SHORT    = 1850,
  parameter int unsigned T_LONG     = 76000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 20
) (
  input  logic       in_clock,
  input  logic       rst,
  input  logic       wr_stb,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       full,
  output logic       ovf,
  output logic       init_done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_db
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  localparam logic [2:0] ST_PWRUP = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_IDLE  = 3'd2;
  localparam logic [2:0] ST_SETUP = 3'd3;
  localparam logic [2:0] ST_PULSE = 3'd4;
  localparam logic [2:0] ST_HOLD  = 3'd5;
  localparam logic [2:0] ST_WAIT  = 3'd6;

  localparam logic [2:0] INIT_LAST = 3'd5;

  // Terminal count for a timed state. A state lasts T clocks, so the counter
  // runs 0..T-1. A value of 0 is treated as 1.
  function automatic logic [CNT_W-1:0] f_lim(input int unsigned t);
    if (t <= 1) return '0;
    else        return CNT_W'(t - 1);
  endfunction

  function automatic logic [7:0] f_rom(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: f_rom = 8'h38;
      3'd3:             f_rom = 8'h0C;
      3'd4:             f_rom = 8'h06;
      default:          f_rom = 8'h01;
    endcase
  endfunction

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic             r_init_done;
  logic             r_rs;
  logic [7:0]       r_db;
  logic             r_ovf;
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [8:0]       r_mem [FIFO_DEPTH];

  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic [8:0]       w_head;
  logic             w_long;
  logic [CNT_W-1:0] w_lim;
  logic             w_tick;

  // The pointers are one bit wider than the index. When the indices match,
  // the extra bit tells empty from full.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

  assign w_pop  = (r_state == ST_IDLE) && r_init_done && !w_empty;
  // A pop on the same edge frees a slot, so a push into a full FIFO is still accepted.
  assign w_push = wr_stb && (!w_full || w_pop);

  // Clear and return-home need the long execution delay.
  assign w_long = !r_rs && (r_db[7:2] == 6'd0);

  always_comb begin
    w_lim = '0;
    case (r_state)
      ST_PWRUP: w_lim = f_lim(T_POWERUP);
      ST_SETUP: w_lim = f_lim(T_SETUP);
      ST_PULSE: w_lim = f_lim(T_PULSE);
      ST_HOLD:  w_lim = f_lim(T_HOLD);
      ST_WAIT:  w_lim = w_long ? f_lim(T_LONG) : f_lim(T_SHORT);
      default:  w_lim = '0;
    endcase
  end

  assign w_tick = (r_cnt == w_lim);

  always_ff @(posedge in_clock) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push)           r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)            r_rd_ptr <= r_rd_ptr + 1'b1;
      if (wr_stb && !w_push) r_ovf   <= 1'b1;
    end
  end

  always_ff @(posedge in_clock) begin
    if (!rst && w_push) r_mem[r_wr_ptr[AW-1:0]] <= {wr_rs, wr_data};
  end

  always_ff @(posedge in_clock) begin
    if (rst) begin
      r_state     <= ST_PWRUP;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_init_done <= 1'b0;
      r_rs        <= 1'b0;
      r_db        <= '0;
    end else begin
      case (r_state)
        ST_PWRUP: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= ST_INIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_INIT: begin
          r_rs    <= 1'b0;
          r_db    <= f_rom(r_idx);
          r_cnt   <= '0;
          r_state <= ST_SETUP;
        end
        ST_IDLE: begin
          if (w_pop) begin
            r_rs    <= w_head[8];
            r_db    <= w_head[7:0];
            r_cnt   <= '0;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP, ST_PULSE, ST_HOLD: begin
          if (w_tick) begin
            r_cnt <= '0;
            case (r_state)
              ST_SETUP: r_state <= ST_PULSE;
              ST_PULSE: r_state <= ST_HOLD;
              default:  r_state <= ST_WAIT;
            endcase
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_WAIT: begin
          if (w_tick) begin
            r_cnt <= '0;
            if (r_init_done) begin
              r_state <= ST_IDLE;
            end else if (r_idx == INIT_LAST) begin
              r_init_done <= 1'b1;
              r_state     <= ST_IDLE;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_state <= ST_INIT;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= ST_PWRUP;
        end
      endcase
    end
  end

  assign busy      = !r_init_done || !w_empty || (r_state != ST_IDLE);
  assign full      = w_full;
  assign ovf       = r_ovf;
  assign init_done = r_init_done;
  // E is decoded from the registered state, so a reset drops it on the same edge.
  assign lcd_e     = (r_state == ST_PULSE);
  assign lcd_rs    = r_rs;
  assign lcd_rw    = 1'b0;
  assign lcd_db    = r_db;

endmodule

// File: tb/tb_lcd1602_seq.sv
// Testbench for lcd1602_seq. It runs directed and random stimulus.
// The reference model is a transaction timeline: a queue of pending bytes and
// the start edge of each bus cycle. Every expected output is derived from these.
module tb_lcd1602_seq;

  localparam int S     = 2;
  localparam int P     = 3;
  localparam int H     = 2;
  localparam int TS    = 5;
  localparam int TL    = 20;
  localparam int TPW   = 10;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_stb;
  logic       wr_rs;
  logic [7:0] wr_data;
  logic       busy, full, ovf, init_done, lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_db;

  always #5 clk = ~clk;

  lcd1602_seq #(
    .T_POWERUP (TPW),
    .T_SETUP   (S),
    .T_PULSE   (P),
    .T_HOLD    (H),
    .T_SHORT   (TS),
    .T_LONG    (TL),
    .FIFO_DEPTH(DEPTH),
    .CNT_W     (20)
  ) dut (
    .in_clock (clk),
    .rst      (rst),
    .wr_stb   (wr_stb),
    .wr_rs    (wr_rs),
    .wr_data  (wr_data),
    .busy     (busy),
    .full     (full),
    .ovf      (ovf),
    .init_done(init_done),
    .lcd_e    (lcd_e),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_db   (lcd_db)
  );

  // Reference model state
  int         m_cyc;      // index of the next non-reset edge
  logic [8:0] m_q[$];     // pending FIFO entries
  logic [8:0] m_rom[$];   // init commands not yet started
  logic [8:0] m_emit[$];  // bytes expected on E rising edges, in order
  int         m_next;     // earliest edge for the next bus-cycle start
  int         m_done_at;  // edge that sets init_done (-1 = not yet known)
  bit         m_have;     // a bus cycle has started since reset
  int         m_cs, m_cd; // current cycle start edge and total duration
  logic       m_rs;
  logic [7:0] m_db;
  logic       m_ovf;

  int   n_checks = 0;
  int   n_errors = 0;
  logic prev_e;
  int   e_run;

  function automatic int dur(input logic [8:0] ent);
    return S + P + H + ((ent[8] == 1'b0 && ent[7:2] == 6'd0) ? TL : TS);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_rom = '{9'h038, 9'h038, 9'h038, 9'h00C, 9'h006, 9'h001};
    m_emit = m_rom;
    m_cyc = 0;
    m_next = TPW;
    m_done_at = -1;
    m_have = 0;
    m_cs = 0;
    m_cd = 0;
    m_rs = 1'b0;
    m_db = 8'h00;
    m_ovf = 1'b0;
    prev_e = 1'b0;
    e_run = 0;
  endtask

  task automatic model_load(input logic [8:0] ent);
    m_have = 1;
    m_cs = m_cyc;
    m_cd = dur(ent);
    m_rs = ent[8];
    m_db = ent[7:0];
    m_next = m_cyc + m_cd + 1;
  endtask

  task automatic model_edge(input logic stb, input logic rs, input logic [7:0] d);
    int sz;
    bit popped;
    logic [8:0] ent;
    sz = m_q.size();
    popped = 0;
    if (m_rom.size() > 0) begin
      if (m_cyc == m_next) begin
        ent = m_rom.pop_front();
        model_load(ent);
        if (m_rom.size() == 0) m_done_at = m_cyc + m_cd;
      end
    end else if (m_cyc >= m_next && sz > 0) begin
      ent = m_q.pop_front();
      model_load(ent);
      popped = 1;
    end
    if (stb) begin
      if (sz < DEPTH || popped) begin
        m_q.push_back({rs, d});
        m_emit.push_back({rs, d});
      end else begin
        m_ovf = 1'b1;
      end
    end
    m_cyc++;
  endtask

  task automatic check_outputs();
    int   e;
    logic x_e, x_done, x_busy;
    logic [8:0] x_byte;
    e = m_cyc - 1;
    x_e = m_have && (e >= m_cs + S) && (e < m_cs + S + P);
    x_done = (m_done_at >= 0) && (e >= m_done_at);
    x_busy = !x_done || (m_q.size() != 0) || (m_have && e < m_cs + m_cd);
    chk("lcd_e", lcd_e, x_e);
    chk("lcd_rs", lcd_rs, m_rs);
    chk("lcd_db", lcd_db, m_db);
    chk("lcd_rw", lcd_rw, 1'b0);
    chk("init_done", init_done, x_done);
    chk("busy", busy, x_busy);
    chk("full", full, m_q.size() == DEPTH);
    chk("ovf", ovf, m_ovf);
    if (lcd_e && !prev_e) begin
      x_byte = (m_emit.size() > 0) ? m_emit.pop_front() : 9'bx;
      chk("emit_order", {lcd_rs, lcd_db}, x_byte);
      e_run = 1;
    end else if (lcd_e) begin
      e_run++;
    end else if (prev_e) begin
      chk("e_width", e_run, P);
    end
    prev_e = lcd_e;
  endtask

  task automatic step(input logic r, input logic stb, input logic rs, input logic [7:0] d);
    @(negedge clk);
    rst = r;
    wr_stb = stb;
    wr_rs = rs;
    wr_data = d;
    if (r) model_reset();
    else   model_edge(stb, rs, d);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  function automatic bit model_idle();
    return (m_done_at >= 0) && (m_cyc - 1 >= m_cs + m_cd) && (m_q.size() == 0);
  endfunction

  task automatic run_until_idle(input int limit);
    int n;
    for (n = 0; n < limit && !model_idle(); n++) step(1'b0, 1'b0, 1'b0, 8'h00);
    assert (n < limit) else begin
      n_checks++;
      n_errors++;
      $error("FAIL idle_timeout: got %0d cycles expected < %0d", n, limit);
    end
    chk("idle_busy", busy, 1'b0);
  endtask

  initial begin
    logic [7:0] d;
    logic       rs;
    rst = 1'b1;
    wr_stb = 1'b0;
    wr_rs = 1'b0;
    wr_data = 8'h00;
    model_reset();

    // Reset state
    repeat (3) step(1'b1, 1'b0, 1'b0, 8'h00);

    // Init sequence
    run_until_idle(500);
    chk("init_all_emitted", m_emit.size(), 0);

    // Single data write
    step(1'b0, 1'b1, 1'b1, 8'h41);
    run_until_idle(100);

    // Long vs short execution delay
    step(1'b0, 1'b1, 1'b0, 8'h02);
    step(1'b0, 1'b1, 1'b0, 8'h80);
    run_until_idle(200);

    // Push into a full FIFO on the pop edge
    step(1'b0, 1'b1, 1'b0, 8'h01);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
    for (int n = 0; n < 100 && m_cyc != m_next; n++) step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("full_before_pop", full, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'hA5);
    chk("ovf_after_simul", ovf, 1'b0);
    run_until_idle(300);

    // Overflow
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 8'($urandom));
    chk("full_after_5", full, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'hEE);
    chk("ovf_set", ovf, 1'b1);
    run_until_idle(300);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      rs = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      step(1'b0, ($urandom_range(0, 3) == 0), rs, d);
    end
    run_until_idle(400);

    // Reset during E pulse
    step(1'b0, 1'b1, 1'b1, 8'h55);
    for (int n = 0; n < 50 && !lcd_e; n++) step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("e_high_before_rst", lcd_e, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("rst_lcd_e", lcd_e, 1'b0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_busy", busy, 1'b1);
    run_until_idle(500);
    chk("reinit_all_emitted", m_emit.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lcd1602_seq.md
Name: lcd1602_seq

Overview:
Write-only sequencer for the HD44780-compatible LCD1602 on the Z80 I/O bus. It replaces direct CPU toggling of lcd_e, lcd_rs and lcd_rw.
- CPU-side writes (data byte plus RS bit) enter a small FIFO.
- The block generates the power-on init sequence, then each bus cycle: setup, E pulse, hold, execution delay.
- It exposes busy, full and a sticky overflow flag so firmware can poll instead of using software delays.

Parameters:
T_POWERUP, 750000, clocks to wait after reset before the first init command.
T_SETUP, 2, clocks RS/DB are stable before E rises.
T_PULSE, 12, clocks E is held high.
T_HOLD, 2, clocks RS/DB are held after E falls.
T_SHORT, 1850, execution delay for ordinary commands and data.
T_LONG, 76000, execution delay for clear/home (RS=0, data[7:2]==0).
FIFO_DEPTH, 4, CPU write FIFO entries, power of two, minimum 2.
CNT_W, 20, delay counter width; must hold the largest T_*.

Ports:
in_clock  in  1  system clock; all logic on its rising edge.
rst  in  1  synchronous reset, active-high.
wr_stb  in  1  one-cycle write strobe, already synchronised to in_clock.
wr_rs  in  1  RS value for the pushed byte (0 = command, 1 = data).
wr_data  in  8  byte to send.
busy  out  1  high while init is pending, the FIFO is non-empty, or a transfer/delay is in progress.
full  out  1  FIFO holds FIFO_DEPTH entries.
ovf  out  1  sticky: a write was dropped; cleared only by rst.
init_done  out  1  high once the init sequence completes; stays high until rst.
lcd_e  out  1  LCD enable.
lcd_rs  out  1  LCD register select.
lcd_rw  out  1  LCD read/write; constant 0.
lcd_db  out  8  LCD data bus.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Outputs: lcd_e=0, lcd_rs=0, lcd_db=0, busy=1, init_done=0, full=0, ovf=0.
  - FIFO emptied, counter cleared, state=PWRUP.
  - Reset mid-transfer aborts it: lcd_e drops to 0 on that same edge.
- States: PWRUP, INIT, IDLE, SETUP, PULSE, HOLD, WAIT.
- PWRUP: count T_POWERUP clocks, then go to INIT with init index 0.
- INIT: issue the fixed ROM sequence (RS=0) through SETUP/PULSE/HOLD/WAIT, one command at a time.
  - Sequence: 0x38, 0x38, 0x38, 0x0C, 0x06, 0x01.
  - After the last command's WAIT, set init_done=1 and go to IDLE.
- FIFO during init: accepts writes but is not popped until init_done.
- IDLE with FIFO non-empty: pop the head on this edge, drive lcd_rs/lcd_db from it, go to SETUP.
- SETUP: lcd_e=0 for T_SETUP clocks, then PULSE.
- PULSE: lcd_e=1 for T_PULSE clocks, then HOLD.
- HOLD: lcd_e=0 for T_HOLD clocks, then WAIT.
- RS/DB stability: lcd_rs and lcd_db stay unchanged from SETUP entry to HOLD exit.
- WAIT: lcd_e=0 for T_LONG clocks if RS=0 and data[7:2]==0, otherwise T_SHORT clocks; then IDLE.
- Back-to-back entries: the next entry starts on the first IDLE clock, so there is no idle gap.
- Delay counting: each timed state lasts exactly its T_* value in clocks. A value of 0 is treated as 1.
- FIFO: circular with pointers one bit wider than the index; wrap-around is transparent.
- Write when not full: entry accepted.
- Write when full: write dropped and ovf set, except on a simultaneous pop edge, where the push is accepted and full is unchanged.
- Push while empty and IDLE: the entry is visible next cycle, so a transfer starts 1 clock after the strobe edge.
- busy: combinational = !init_done | fifo_nonempty | (state != IDLE).
- full: registered or combinational from the pointers; either way it must be valid in the same cycle as the FIFO state.
- lcd_rw: never driven to 1.

Test Plan:
1. Init timing (bench overrides T_POWERUP=10, T_SHORT=5, T_LONG=20, T_SETUP=2, T_PULSE=3, T_HOLD=2): release rst → 6 E pulses carrying 0x38, 0x38, 0x38, 0x0C, 0x06, 0x01 with RS=0; each E pulse 3 clocks wide; init_done=1 exactly after the 0x01 long wait; busy falls the same cycle.
2. Single data write after init: wr_stb with rs=1, data=0x41 → lcd_db=0x41 and lcd_rs=1 held 2 clocks before E rises; E high 3 clocks; data held 2 clocks after E falls; 5-clock wait; busy high throughout, low afterwards.
3. Long-delay decode: push RS=0 0x02, then RS=0 0x80 → first waits 20 clocks, second waits 5; 0x80 sent immediately after the first wait.
4. FIFO full/overflow: after init, with state IDLE and FIFO empty, push 5 bytes back-to-back → first pops immediately, so 4 remain queued with full=1 and ovf stays 0; a 6th push while full with no pop is dropped, ovf=1; bytes appear on lcd_db in push order.
5. Simultaneous push and pop at full: push on the IDLE-to-SETUP pop edge while full=1 → write accepted, ovf unchanged, all entries emitted in order.
6. Reset mid-PULSE: assert rst while lcd_e=1 → lcd_e=0 on that edge; FIFO empty, init_done=0, ovf=0; init sequence restarts from PWRUP.
